spi_fl_seq: RTL and testbench
=============================

Name: spi_fl_seq

Overview:
- Flash operation sequencer directly upstream of the SPI flash master; drives its command/address/data/commtype/nmiso_bits/dummy_cycles/validflag inputs and consumes tready/data_out.
- Turns one high-level request (READ, PROGRAM, ERASE, READ_ID) into the required chain of SPI transactions.
- Inserts WREN (06h) before PROGRAM and ERASE, then polls the status register (05h) until WIP clears.
- Returns one response (read data plus error flag) per request.

Parameters:
- POLL_MAX, 65535, maximum status polls before a timeout error is flagged.
- GAP_CLKS, 8, minimum clk cycles between consecutive SPI transactions (SS deasserted time).
- POLL_W, 16, width of the poll counter; must satisfy 2^POLL_W > POLL_MAX.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  sequencer idle, request accepted when req_valid&req_ready
- req_op  in  2  0=READ 1=PROGRAM 2=ERASE 3=READ_ID
- req_addr  in  24  flash byte address
- req_wdata  in  32  PROGRAM data (4 bytes, MSB first)
- req_nbytes  in  3  READ length, 1..4 (0 and >4 treated as 4)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  right-justified read data / ID
- resp_error  out  1  poll timeout flagged with resp_valid
- spi_command  out  8  to master command
- spi_address  out  32  to master address ({8'h0,addr})
- spi_data_in  out  32  to master data_in
- spi_commtype  out  3  to master commtype
- spi_nmiso_bits  out  7  to master nmiso_bits
- spi_dummy_cycles  out  4  to master dummy_cycles (always 0)
- spi_validflag  out  1  to master validflag
- spi_tready  in  1  from master tready
- spi_data_out  in  32  from master data_out

Behaviour:
- Reset (rst_n low, async): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_error=0; spi_validflag=0; all spi_* fields 0; counters 0. Reset mid-transaction aborts immediately, no response.
- Accept: in IDLE, req_valid&req_ready registers op/addr/wdata/nbytes; req_ready=0 the next cycle; step index cleared.
- Step tables (command, commtype, nmiso):
  - READ: 03h,010,8*n.
  - READ_ID: 9Fh,001,24.
  - PROGRAM: 06h,000,0 -> 02h,100,0 (data_in=wdata) -> POLL.
  - ERASE: 06h,000,0 -> 20h,101,0 -> POLL.
  - POLL step: 05h,001,8.
- FSM IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> GAP -> (ISSUE | DONE).
  - ISSUE: drive spi_* fields, spi_validflag=1.
  - WAIT_ACK: hold validflag and fields until spi_tready=0; then drop validflag.
  - WAIT_DONE: wait spi_tready=1; capture spi_data_out.
  - GAP: count GAP_CLKS, then advance the step or finish.
  - Fields stay stable from ISSUE until WAIT_DONE exit.
- spi_validflag is low for at least one cycle between transactions; the master only accepts on a validflag low->high edge.
- Poll evaluation: WIP = spi_data_out[24] (master packs received bits from bit 31 down).
  - WIP=1 and poll_cnt<POLL_MAX: increment, reissue POLL.
  - WIP=0: DONE with error=0.
  - poll_cnt reaches POLL_MAX with WIP still 1: DONE with resp_error=1.
- Result shaping:
  - READ: resp_rdata = spi_data_out >> (32-8n).
  - READ_ID: spi_data_out >> 8.
  - PROGRAM/ERASE: 0.
- DONE: resp_valid=1 for exactly one cycle, then IDLE with req_ready=1 the same cycle. resp_rdata/resp_error hold until the next response.
- req_valid while busy is ignored (req_ready=0). No backpressure on the response.

Decomposition:
- Shared package spi_fl_pkg:
  - opcode constants CMD_READ=03h, CMD_PP=02h, CMD_SE=20h, CMD_WREN=06h, CMD_RDSR=05h, CMD_RDID=9Fh
  - commtype constants CT_CMD=000, CT_CMD_ANS=001, CT_CMD_ADDR_ANS=010, CT_CMD_ADDR_DATA=100, CT_CMD_ADDR=101
  - op encodings; FSM state encodings
- One sub-module spi_fl_txn: the ISSUE/WAIT_ACK/WAIT_DONE/GAP handshake with the master. Step sequencing and poll logic live in the parent.

Test Plan:
- READ addr=0x012345, n=2; master model returns data_out=0xBEEF0000. Expect:
  - one transaction: cmd 03h, commtype 010, nmiso 16, address 0x00012345
  - resp_rdata=0x0000BEEF, error=0
- PROGRAM addr=0x000100, wdata=0xA5A5A5A5; model WIP=1 for 3 polls, then 0. Expect:
  - transaction sequence 06h, 02h (data_in=0xA5A5A5A5, commtype 100), then 05h x4
  - single resp_valid, error=0
- ERASE with POLL_MAX=4 and WIP stuck at 1. Expect exactly 4 polls (POLL_MAX), then resp_valid with resp_error=1.
- READ_ID; model data_out=0xEF401800. Expect resp_rdata=0x00EF4018; req_valid asserted during busy is ignored (no second transaction).
- Handshake: delay the master tready drop by 5 cycles. Expect:
  - validflag and fields held stable until the drop
  - validflag low for at least 1 cycle and SS gap of at least GAP_CLKS between transactions
- Assert rst_n low mid-PROGRAM (in WAIT_DONE). Expect:
  - all outputs at reset values asynchronously, no resp_valid
  - after release, a new READ completes normally

Source files
------------

// File: rtl/spi_fl_pkg.sv
// Shared opcodes, SPI master commtype codes, request op encodings and FSM
// state types for the flash operation sequencer.
package spi_fl_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'h20;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  localparam logic [2:0] CT_CMD           = 3'b000;
  localparam logic [2:0] CT_CMD_ANS       = 3'b001;
  localparam logic [2:0] CT_CMD_ADDR_ANS  = 3'b010;
  localparam logic [2:0] CT_CMD_ADDR_DATA = 3'b100;
  localparam logic [2:0] CT_CMD_ADDR      = 3'b101;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_READ_ID = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_RUN
  } seq_state_t;

  typedef enum logic [1:0] {
    TXN_IDLE,
    TXN_WAIT_ACK,
    TXN_WAIT_DONE,
    TXN_GAP
  } txn_state_t;

  // READ length: 1..4 bytes, anything else means 4
  function automatic logic [2:0] read_len(input logic [2:0] n);
    return (n == 3'd0 || n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/spi_fl_txn.sv
// One SPI master transaction: present fields with a validflag rising edge,
// wait for the master to take it (tready low) and finish (tready high),
// capture data_out, then hold off GAP_CLKS cycles before reporting done.
module spi_fl_txn
  import spi_fl_pkg::*;
#(
  parameter int unsigned GAP_CLKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [2:0]  ctype,
  input  logic [6:0]  nmiso,
  output logic        done,
  output logic [31:0] rdata,
  output logic [7:0]  spi_command,
  output logic [31:0] spi_address,
  output logic [31:0] spi_data_in,
  output logic [2:0]  spi_commtype,
  output logic [6:0]  spi_nmiso_bits,
  output logic [3:0]  spi_dummy_cycles,
  output logic        spi_validflag,
  input  logic        spi_tready,
  input  logic [31:0] spi_data_out
);

  txn_state_t  state;
  logic [31:0] gap_cnt;

  assign spi_dummy_cycles = '0;

  // Handshake FSM; fields are latched at start and held through WAIT_DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= TXN_IDLE;
      done           <= 1'b0;
      rdata          <= '0;
      gap_cnt        <= '0;
      spi_command    <= '0;
      spi_address    <= '0;
      spi_data_in    <= '0;
      spi_commtype   <= '0;
      spi_nmiso_bits <= '0;
      spi_validflag  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        TXN_IDLE: begin
          if (start) begin
            spi_command    <= cmd;
            spi_address    <= addr;
            spi_data_in    <= data;
            spi_commtype   <= ctype;
            spi_nmiso_bits <= nmiso;
            spi_validflag  <= 1'b1;
            state          <= TXN_WAIT_ACK;
          end
        end
        TXN_WAIT_ACK: begin
          if (!spi_tready) begin
            spi_validflag <= 1'b0;
            state         <= TXN_WAIT_DONE;
          end
        end
        TXN_WAIT_DONE: begin
          if (spi_tready) begin
            rdata   <= spi_data_out;
            gap_cnt <= '0;
            state   <= TXN_GAP;
          end
        end
        TXN_GAP: begin
          if (gap_cnt + 32'd1 >= GAP_CLKS) begin
            done  <= 1'b1;
            state <= TXN_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: state <= TXN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_fl_seq.sv
// Flash operation sequencer: expands READ / PROGRAM / ERASE / READ_ID
// requests into SPI master transactions (WREN first for writes, then RDSR
// polling until WIP clears or POLL_MAX polls) and returns one response.
module spi_fl_seq
  import spi_fl_pkg::*;
#(
  parameter int unsigned POLL_MAX = 65535,
  parameter int unsigned GAP_CLKS = 8,
  parameter int unsigned POLL_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_nbytes,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [7:0]  spi_command,
  output logic [31:0] spi_address,
  output logic [31:0] spi_data_in,
  output logic [2:0]  spi_commtype,
  output logic [6:0]  spi_nmiso_bits,
  output logic [3:0]  spi_dummy_cycles,
  output logic        spi_validflag,
  input  logic        spi_tready,
  input  logic [31:0] spi_data_out
);

  seq_state_t        state;
  op_t               op;
  logic [23:0]       addr;
  logic [31:0]       wdata;
  logic [2:0]        nbytes;
  logic [1:0]        step;
  logic [POLL_W-1:0] poll_cnt;

  logic        txn_start;
  logic        txn_done;
  logic [31:0] txn_rdata;
  logic [7:0]  s_cmd;
  logic [2:0]  s_ct;
  logic [6:0]  s_nmiso;
  logic [31:0] s_data;
  logic [31:0] read_shaped;

  assign txn_start = (state == SEQ_ISSUE);

  // Step table: fields of the current transaction for (op, step)
  always_comb begin
    s_cmd       = CMD_RDSR;
    s_ct        = CT_CMD_ANS;
    s_nmiso     = 7'd8;
    s_data      = '0;
    read_shaped = txn_rdata >> (6'd32 - {nbytes, 3'b000});
    case (op)
      OP_READ: begin
        s_cmd   = CMD_READ;
        s_ct    = CT_CMD_ADDR_ANS;
        s_nmiso = {1'b0, nbytes, 3'b000};
      end
      OP_READ_ID: begin
        s_cmd   = CMD_RDID;
        s_ct    = CT_CMD_ANS;
        s_nmiso = 7'd24;
      end
      OP_PROGRAM: begin
        if (step == 2'd0) begin
          s_cmd   = CMD_WREN;
          s_ct    = CT_CMD;
          s_nmiso = 7'd0;
        end else if (step == 2'd1) begin
          s_cmd   = CMD_PP;
          s_ct    = CT_CMD_ADDR_DATA;
          s_nmiso = 7'd0;
          s_data  = wdata;
        end
      end
      OP_ERASE: begin
        if (step == 2'd0) begin
          s_cmd   = CMD_WREN;
          s_ct    = CT_CMD;
          s_nmiso = 7'd0;
        end else if (step == 2'd1) begin
          s_cmd   = CMD_SE;
          s_ct    = CT_CMD_ADDR;
          s_nmiso = 7'd0;
        end
      end
      default: ;
    endcase
  end

  // Request sequencing and poll evaluation. The response is issued on the
  // final transition into IDLE, so resp_valid and req_ready rise together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEQ_IDLE;
      op         <= OP_READ;
      addr       <= '0;
      wdata      <= '0;
      nbytes     <= '0;
      step       <= '0;
      poll_cnt   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (req_valid) begin
            op        <= op_t'(req_op);
            addr      <= req_addr;
            wdata     <= req_wdata;
            nbytes    <= read_len(req_nbytes);
            step      <= '0;
            poll_cnt  <= '0;
            req_ready <= 1'b0;
            state     <= SEQ_ISSUE;
          end
        end
        SEQ_ISSUE: state <= SEQ_RUN;
        SEQ_RUN: begin
          if (txn_done) begin
            if (op == OP_READ || op == OP_READ_ID) begin
              resp_valid <= 1'b1;
              resp_rdata <= (op == OP_READ) ? read_shaped : (txn_rdata >> 8);
              resp_error <= 1'b0;
              req_ready  <= 1'b1;
              state      <= SEQ_IDLE;
            end else if (step != 2'd2) begin
              step  <= step + 2'd1;
              state <= SEQ_ISSUE;
            end else if (!txn_rdata[24] || (32'(poll_cnt) + 32'd1 >= POLL_MAX)) begin
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_error <= txn_rdata[24];
              req_ready  <= 1'b1;
              state      <= SEQ_IDLE;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              state    <= SEQ_ISSUE;
            end
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

  spi_fl_txn #(
    .GAP_CLKS(GAP_CLKS)
  ) u_txn (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (txn_start),
    .cmd             (s_cmd),
    .addr            ({8'h00, addr}),
    .data            (s_data),
    .ctype           (s_ct),
    .nmiso           (s_nmiso),
    .done            (txn_done),
    .rdata           (txn_rdata),
    .spi_command     (spi_command),
    .spi_address     (spi_address),
    .spi_data_in     (spi_data_in),
    .spi_commtype    (spi_commtype),
    .spi_nmiso_bits  (spi_nmiso_bits),
    .spi_dummy_cycles(spi_dummy_cycles),
    .spi_validflag   (spi_validflag),
    .spi_tready      (spi_tready),
    .spi_data_out    (spi_data_out)
  );

endmodule

// File: tb/tb_spi_fl_seq.sv
// Bench for spi_fl_seq: behavioural SPI master model plus a request-level
// reference that predicts the transaction list and response of each request.
module tb_spi_fl_seq;

  localparam int unsigned POLL_MAX = 4;
  localparam int unsigned GAP_CLKS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_nbytes;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [7:0]  spi_command;
  logic [31:0] spi_address, spi_data_in, spi_data_out;
  logic [2:0]  spi_commtype;
  logic [6:0]  spi_nmiso_bits;
  logic [3:0]  spi_dummy_cycles;
  logic        spi_validflag, spi_tready;

  always #5 clk = ~clk;

  spi_fl_seq #(
    .POLL_MAX(POLL_MAX),
    .GAP_CLKS(GAP_CLKS),
    .POLL_W  (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_nbytes      (req_nbytes),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .spi_command     (spi_command),
    .spi_address     (spi_address),
    .spi_data_in     (spi_data_in),
    .spi_commtype    (spi_commtype),
    .spi_nmiso_bits  (spi_nmiso_bits),
    .spi_dummy_cycles(spi_dummy_cycles),
    .spi_validflag   (spi_validflag),
    .spi_tready      (spi_tready),
    .spi_data_out    (spi_data_out)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  ct;
    logic [6:0]  nm;
  } txn_t;

  txn_t seen[$];
  txn_t expq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // master model knobs and observations
  int          ack_delay = 1;
  int          busy_cycles = 3;
  int          wip_left = 0;      // polls still answering WIP=1; negative = forever
  logic [31:0] rd_word = '0;
  int          m_state = 0;
  int          stable_viol = 0;
  int          gap_viol = 0;
  int          vf_viol = 0;
  int          resp_count = 0;

  always @(negedge clk) if (resp_valid === 1'b1) resp_count++;

  // Behavioural SPI master: accepts on validflag rising edge, drops tready
  // after ack_delay cycles, completes after busy_cycles more.
  initial begin
    int   cnt;
    int   gap;
    logic prev_vf;
    logic wip;
    txn_t cur;
    cnt = 0; gap = 1000; prev_vf = 1'b0;
    spi_tready = 1'b1;
    spi_data_out = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        m_state = 0; spi_tready = 1'b1; prev_vf = 1'b0; gap = 1000;
      end else begin
        case (m_state)
          0: begin
            if (spi_validflag === 1'b1 && prev_vf === 1'b0) begin
              cur.cmd = spi_command; cur.addr = spi_address; cur.data = spi_data_in;
              cur.ct = spi_commtype; cur.nm = spi_nmiso_bits;
              seen.push_back(cur);
              if (gap < int'(GAP_CLKS)) gap_viol++;
              cnt = 0; m_state = 1;
            end else begin
              gap++;
            end
          end
          1: begin
            if (spi_validflag !== 1'b1 || spi_command !== cur.cmd || spi_address !== cur.addr ||
                spi_data_in !== cur.data || spi_commtype !== cur.ct || spi_nmiso_bits !== cur.nm)
              stable_viol++;
            cnt++;
            if (cnt >= ack_delay) begin spi_tready = 1'b0; cnt = 0; m_state = 2; end
          end
          default: begin
            if (spi_command !== cur.cmd || spi_address !== cur.addr || spi_data_in !== cur.data ||
                spi_commtype !== cur.ct || spi_nmiso_bits !== cur.nm)
              stable_viol++;
            cnt++;
            if (cnt >= busy_cycles) begin
              if (spi_validflag !== 1'b0) vf_viol++;
              if (cur.cmd == 8'h05) begin
                wip = (wip_left != 0);
                if (wip_left > 0) wip_left--;
                spi_data_out = {7'($urandom), wip, 24'h000000};
              end else if (cur.cmd == 8'h03 || cur.cmd == 8'h9F) begin
                spi_data_out = rd_word;
              end else begin
                spi_data_out = $urandom;
              end
              spi_tready = 1'b1; gap = 0; m_state = 0;
            end
          end
        endcase
        prev_vf = spi_validflag;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int exp_n(input logic [2:0] nb);
    return (nb == 3'd0 || nb > 3'd4) ? 4 : int'(nb);
  endfunction

  function automatic txn_t mk(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] ct, input int nm);
    txn_t t;
    t.cmd = c; t.addr = a; t.data = d; t.ct = ct; t.nm = 7'(nm);
    return t;
  endfunction

  function automatic int exp_polls(input int wip);
    return (wip < 0 || wip >= int'(POLL_MAX)) ? int'(POLL_MAX) : wip + 1;
  endfunction

  function automatic void build_exp(input logic [1:0] op, input logic [23:0] a,
                                    input logic [31:0] wd, input logic [2:0] nb, input int wip);
    expq.delete();
    if (op == 2'd0) expq.push_back(mk(8'h03, {8'h00, a}, 32'h0, 3'b010, 8 * exp_n(nb)));
    else if (op == 2'd3) expq.push_back(mk(8'h9F, 32'h0, 32'h0, 3'b001, 24));
    else begin
      expq.push_back(mk(8'h06, 32'h0, 32'h0, 3'b000, 0));
      if (op == 2'd1) expq.push_back(mk(8'h02, {8'h00, a}, wd, 3'b100, 0));
      else            expq.push_back(mk(8'h20, {8'h00, a}, 32'h0, 3'b101, 0));
      for (int i = 0; i < exp_polls(wip); i++) expq.push_back(mk(8'h05, 32'h0, 32'h0, 3'b001, 8));
    end
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] op, input logic [2:0] nb);
    if (op == 2'd0) return rd_word >> (32 - 8 * exp_n(nb));
    if (op == 2'd3) return rd_word >> 8;
    return 32'h0;
  endfunction

  function automatic logic exp_err(input logic [1:0] op, input int wip);
    return (op == 2'd1 || op == 2'd2) && (wip < 0 || wip >= int'(POLL_MAX));
  endfunction

  // index of first transaction differing from expectation, -2 on count, -1 if none
  function automatic int txn_diff();
    if (seen.size() != expq.size()) return -2;
    foreach (expq[i]) begin
      if (seen[i].cmd !== expq[i].cmd || seen[i].ct !== expq[i].ct || seen[i].nm !== expq[i].nm) return i;
      if ((expq[i].cmd == 8'h03 || expq[i].cmd == 8'h02 || expq[i].cmd == 8'h20) &&
          seen[i].addr !== expq[i].addr) return i;
      if (expq[i].cmd == 8'h02 && seen[i].data !== expq[i].data) return i;
    end
    return -1;
  endfunction

  function automatic string show(input int d);
    if (d < 0) return $sformatf("txn count %0d, need %0d", seen.size(), expq.size());
    return $sformatf("txn %0d cmd=%h ct=%b nm=%0d addr=%h data=%h, need cmd=%h ct=%b nm=%0d addr=%h data=%h",
                     d, seen[d].cmd, seen[d].ct, seen[d].nm, seen[d].addr, seen[d].data,
                     expq[d].cmd, expq[d].ct, expq[d].nm, expq[d].addr, expq[d].data);
  endfunction

  // Issue one request and wait (bounded) for its response.
  task automatic run_req(input logic [1:0] op, input logic [23:0] a, input logic [31:0] wd,
                         input logic [2:0] nb, input bit noise,
                         output bit got, output logic [31:0] rd, output logic er, output int npulse);
    int base;
    int k;
    got = 1'b0; rd = '0; er = 1'b0;
    seen.delete();
    base = resp_count;
    @(negedge clk);
    k = 0;
    while (req_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    req_op = op; req_addr = a; req_wdata = wd; req_nbytes = nb; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      if (noise && c >= 1 && c <= 8) begin
        req_valid = 1'b1; req_op = 2'($urandom); req_addr = 24'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (resp_valid === 1'b1) begin got = 1'b1; rd = resp_rdata; er = resp_error; end
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    npulse = resp_count - base;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_error, resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h, need 1 0 0 00000000",
               req_ready, resp_valid, resp_error, resp_rdata);
    end
    n_cmp++;
    if ({spi_validflag, spi_command, spi_address, spi_data_in, spi_commtype, spi_nmiso_bits, spi_dummy_cycles} !== '0) begin
      n_bad++;
      $display("FAIL reset_spi: vf=%b cmd=%h addr=%h din=%h ct=%b nm=%0d dc=%0d, need all 0",
               spi_validflag, spi_command, spi_address, spi_data_in, spi_commtype, spi_nmiso_bits, spi_dummy_cycles);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, spi_validflag} !== 2'b10) begin
      n_bad++;
      $display("FAIL post_reset_idle: ready=%b vf=%b, need 1 0", req_ready, spi_validflag);
    end
  endtask

  task automatic check_req(input string name, input logic [1:0] op, input logic [23:0] a,
                           input logic [31:0] wd, input logic [2:0] nb, input int wip, input bit noise);
    bit got; logic [31:0] rd; logic er; int np; int d;
    logic [31:0] e_rd; logic e_er;
    wip_left = wip;
    build_exp(op, a, wd, nb, wip);
    e_rd = exp_rdata(op, nb);
    e_er = exp_err(op, wip);
    run_req(op, a, wd, nb, noise, got, rd, er, np);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL %s_timeout: no resp_valid, need one", name);
    end else if ({er, rd} !== {e_er, e_rd}) begin
      n_bad++; $display("FAIL %s_resp: rdata=%h err=%b, need rdata=%h err=%b", name, rd, er, e_rd, e_er);
    end
    d = txn_diff();
    n_cmp++;
    if (d != -1) begin n_bad++; $display("FAIL %s_txns: %s", name, show(d)); end
    n_cmp++;
    if (np !== 1) begin n_bad++; $display("FAIL %s_pulses: %0d resp_valid cycles, need 1", name, np); end
  endtask

  task automatic test_read();
    rd_word = 32'hBEEF0000;
    check_req("read_dir", 2'd0, 24'h012345, 32'h0, 3'd2, 0, 1'b0);
    n_cmp++;
    if (resp_rdata !== 32'h0000BEEF) begin
      n_bad++; $display("FAIL read_hold: resp_rdata=%h, need 0000BEEF", resp_rdata);
    end
    for (int i = 0; i < 6; i++) begin
      rd_word = $urandom;
      check_req("read_rnd", 2'd0, 24'($urandom), 32'h0, 3'($urandom_range(0, 7)), 0, 1'b0);
    end
  endtask

  task automatic test_program();
    rd_word = '0;
    check_req("prog_dir", 2'd1, 24'h000100, 32'hA5A5A5A5, 3'd0, 3, 1'b0);
    for (int i = 0; i < 3; i++)
      check_req("prog_rnd", 2'd1, 24'($urandom), $urandom, 3'($urandom), $urandom_range(0, 3), 1'b0);
  endtask

  task automatic test_erase();
    check_req("erase_stuck", 2'd2, 24'h00F000, 32'h0, 3'd0, -1, 1'b0);
    n_cmp++;
    if (resp_error !== 1'b1) begin
      n_bad++; $display("FAIL erase_err_hold: resp_error=%b, need 1", resp_error);
    end
    for (int i = 0; i < 3; i++)
      check_req("erase_rnd", 2'd2, 24'($urandom), 32'h0, 3'd0, $urandom_range(0, 5), 1'b0);
  endtask

  task automatic test_read_id();
    rd_word = 32'hEF401800;
    check_req("rdid_dir", 2'd3, 24'h0, 32'h0, 3'd0, 0, 1'b1);
    rd_word = $urandom;
    check_req("rdid_rnd", 2'd3, 24'($urandom), 32'h0, 3'd0, 0, 1'b1);
  endtask

  task automatic test_handshake();
    int sv0, gv0, vv0;
    sv0 = stable_viol; gv0 = gap_viol; vv0 = vf_viol;
    ack_delay = 5; busy_cycles = 6;
    check_req("hs_prog", 2'd1, 24'($urandom), $urandom, 3'd0, 2, 1'b0);
    rd_word = $urandom;
    check_req("hs_read", 2'd0, 24'($urandom), 32'h0, 3'd3, 0, 1'b0);
    ack_delay = 1; busy_cycles = 3;
    n_cmp++;
    if (stable_viol - sv0 !== 0) begin
      n_bad++; $display("FAIL hs_stable: %0d field/validflag changes before tready drop/done, need 0", stable_viol - sv0);
    end
    n_cmp++;
    if (gap_viol - gv0 !== 0) begin
      n_bad++; $display("FAIL hs_gap: %0d gaps shorter than %0d, need 0", gap_viol - gv0, GAP_CLKS);
    end
    n_cmp++;
    if (vf_viol - vv0 !== 0) begin
      n_bad++; $display("FAIL hs_vf_drop: %0d validflag still high at completion, need 0", vf_viol - vv0);
    end
    n_cmp++;
    if (stable_viol + gap_viol + vf_viol !== 0) begin
      n_bad++; $display("FAIL hs_total: %0d handshake violations over whole run, need 0",
                        stable_viol + gap_viol + vf_viol);
    end
  endtask

  task automatic test_reset_mid();
    int base; int k;
    wip_left = -1;
    seen.delete();
    base = resp_count;
    @(negedge clk);
    req_op = 2'd1; req_addr = 24'h000200; req_wdata = 32'h12345678; req_nbytes = 3'd0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!(seen.size() == 2 && m_state == 2) && k < 2000) begin @(negedge clk); k++; end
    @(negedge clk);
    n_cmp++;
    if (k >= 2000) begin n_bad++; $display("FAIL rstmid_reach: page program never in progress, need it"); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_error, resp_rdata, spi_validflag, spi_command, spi_address,
         spi_data_in, spi_commtype, spi_nmiso_bits} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0, 32'h0, 3'h0, 7'h0}) begin
      n_bad++;
      $display("FAIL rstmid_async: ready=%b valid=%b err=%b rdata=%h vf=%b cmd=%h addr=%h din=%h ct=%b nm=%0d, need reset values",
               req_ready, resp_valid, resp_error, resp_rdata, spi_validflag, spi_command, spi_address,
               spi_data_in, spi_commtype, spi_nmiso_bits);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (resp_count - base !== 0) begin
      n_bad++; $display("FAIL rstmid_noresp: %0d responses after abort, need 0", resp_count - base);
    end
    rd_word = $urandom;
    check_req("rstmid_read", 2'd0, 24'($urandom), 32'h0, 3'd4, 0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_nbytes = '0;
    test_reset();
    test_read();
    test_program();
    test_erase();
    test_read_id();
    test_handshake();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
